// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: round-robin APB master that shares a single APB RAM slave
// between NREQ local requesters. Only one APB transfer is in flight at a time.
// Every output comes straight from a register.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to bound the ACCESS phase.
// After TIMEOUT cycles with pready low, the transfer is aborted and completes
// with rsp_err=1 and rsp_rdata=0. If the macro is not defined, ACCESS waits
// for pready for as long as it takes.

module apb_ram_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  // requester side
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  // APB master side
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grant, grant_n;
  logic [GW-1:0]   rr_ptr, rr_ptr_n;
  logic [GW-1:0]   pick;
  logic            pick_valid;
  logic [NREQ-1:0] eligible;

  logic [NREQ-1:0] done_n;
  logic [DW-1:0]   rsp_rdata_n;
  logic            rsp_err_n;
  logic            busy_n;
  logic            psel_n;
  logic            penable_n;
  logic            pwrite_n;
  logic [AW-1:0]   paddr_n;
  logic [DW-1:0]   pwdata_n;

  // Unpacked views of the packed requester command buses
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
`endif

  // Split the packed command buses into one entry per requester
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      addr_arr[k]  = req_addr[k*AW +: AW];
      wdata_arr[k] = req_wdata[k*DW +: DW];
    end
  end

  // Round-robin pick: first eligible requester at or after rr_ptr, with wrap-around.
  // A requester whose done is high in this cycle is skipped, so it cannot be
  // issued a second time on the same held request.
  always_comb begin
    logic [GW:0] cand;
    // NOTE: each variable assigned in always_comb gets a default value first.
    // This way every path assigns it, and no latch is inferred.
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    eligible   = req & ~done;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
      if (!pick_valid && eligible[cand[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = cand[GW-1:0];
      end
    end
  end

  // Next-state logic. It also produces the next value of every registered output.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    done_n      = '0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_cnt_n   = tmo_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grant_n  = pick;
          pwrite_n = req_write[pick];
          paddr_n  = addr_arr[pick];
          pwdata_n = wdata_arr[pick];
          state_n  = S_SETUP;
        end
      end

      S_SETUP: begin
        state_n = S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_n = '0;
`endif
      end

      S_ACCESS: begin
        if (pready) begin
          done_n[grant] = 1'b1;
          rsp_err_n     = pslverr;
          if (!pwrite) rsp_rdata_n = prdata;
          rr_ptr_n      = (grant == GW'(NREQ-1)) ? '0 : grant + 1'b1;
          state_n       = S_IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // The slave has been stalled for TIMEOUT cycles, so give up on this transfer
        else if (tmo_cnt == TW'(TIMEOUT-1)) begin
          done_n[grant] = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_rdata_n   = '0;
          rr_ptr_n      = (grant == GW'(NREQ-1)) ? '0 : grant + 1'b1;
          state_n       = S_IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
`endif
      end

      default: state_n = S_IDLE;
    endcase

    // The APB strobes and busy depend only on the next state
    psel_n    = (state_n != S_IDLE);
    penable_n = (state_n == S_ACCESS);
    busy_n    = (state_n != S_IDLE);
  end

  // State and output registers. A reset aborts any transfer that is in flight.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= S_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers then
      // update together from values sampled before the edge, and no read order
      // races between blocks.
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_ptr_n;
      done      <= done_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      busy      <= busy_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_n;
`endif
    end
  end

endmodule
